// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, register constants and FIFO entry type
package regfile_wb_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic valid;
    logic squash;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback sources, register-file write port and status signals
interface regfile_wb_arbiter_if #(parameter int DEPTH = 4);
  import regfile_wb_arbiter_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  logic pipe_wr_en;
  logic [ADDR_W-1:0] pipe_wr_addr;
  logic [DATA_W-1:0] pipe_wr_data;
  logic mc_valid;
  logic mc_ready;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic rf_write_control;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic [NUM_REGS-1:0] pending_mask;
  logic [CW-1:0] fifo_count;
  modport master (
    output pipe_wr_en, pipe_wr_addr, pipe_wr_data, mc_valid, mc_addr, mc_data,
    input mc_ready, rf_write_control, rf_rd, rf_wdata, pending_mask, fifo_count
  );
  modport slave (
    input pipe_wr_en, pipe_wr_addr, pipe_wr_data, mc_valid, mc_addr, mc_data,
    output mc_ready, rf_write_control, rf_rd, rf_wdata, pending_mask, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter_wb_squash_fifo.sv
// wb_squash_fifo: multi-cycle result queue with WAW squash and pending-destination mask
module wb_squash_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic pop,
  input  logic sq_en,
  input  logic [ADDR_W-1:0] sq_addr,
  output wb_entry_t head,
  output logic [CW-1:0] count,
  output logic [NUM_REGS-1:0] pending_mask
);
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  assign head = mem[rd_ptr];

  // Storage and pointers; a newer write to the same register kills older queued copies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (mem[i].valid && ((sq_en && mem[i].addr == sq_addr) || (push && mem[i].addr == push_addr)))
          mem[i].squash <= 1'b1;
      if (pop) mem[rd_ptr].valid <= 1'b0;
      if (push) mem[wr_ptr] <= '{addr: push_addr, data: push_data, valid: 1'b1, squash: push_addr == ZERO_REG};
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Destinations still owed a write by a live queued entry
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i].valid && !mem[i].squash) pending_mask[mem[i].addr] = 1'b1;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline writeback and queued multi-cycle results onto the
// register-file write port; define WB_MC_BYPASS_EN to let mc results skip an empty FIFO
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  logic pipe_sel, empty, pop, push, byp, head_wr, wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CW-1:0] count;
  wb_entry_t head;

`ifdef WB_MC_BYPASS_EN
  assign byp = empty && !pipe_sel && bus.mc_valid && bus.mc_addr != ZERO_REG;
`else
  assign byp = 1'b0;
`endif

  assign bus.fifo_count = count;

  // Priority select: pipeline, then FIFO head, then (optionally) direct mc bypass
  always_comb begin
    pipe_sel = bus.pipe_wr_en && bus.pipe_wr_addr != ZERO_REG;
    empty = count == '0;
    pop = !pipe_sel && !empty;
    head_wr = head.valid && !head.squash && head.addr != ZERO_REG;
    bus.mc_ready = !rst && count < CW'(DEPTH);
    push = bus.mc_valid && bus.mc_ready && !byp;
    wr = pipe_sel || (pop && head_wr) || byp;
    wr_addr = pipe_sel ? bus.pipe_wr_addr : pop ? head.addr : bus.mc_addr;
    wr_data = pipe_sel ? bus.pipe_wr_data : pop ? head.data : bus.mc_data;
  end

  wb_squash_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_addr(bus.mc_addr),
    .push_data(bus.mc_data),
    .pop(pop),
    .sq_en(pipe_sel),
    .sq_addr(bus.pipe_wr_addr),
    .head(head),
    .count(count),
    .pending_mask(bus.pending_mask)
  );

  // Registered write port; address/data hold when no write is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rf_write_control <= 1'b0;
      bus.rf_rd <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_write_control <= wr;
      if (wr) begin
        bus.rf_rd <= wr_addr;
        bus.rf_wdata <= wr_data;
      end
    end
  end
endmodule
